yuv444_to_rgb: RTL
==================

# yuv444_to_rgb

Pipelined colour-space converter directly downstream of the 4:2:2→4:4:4 chroma upsampler in the chroma hardware path. It consumes 64-bit 4:4:4 pixel beats on a NASTI stream, converts each pixel from BT.601 YCbCr to 8-bit RGB in fixed point, and emits XRGB beats on a NASTI stream. The output feeds the stream→NASTI mover that writes frames back to memory. Sustained throughput is one beat per cycle.

## Interface

- DATA_WIDTH, 64: stream data width; must be a multiple of 32. LANES = DATA_WIDTH/32 pixels per beat.
- clk  input  1  sole clock; everything is posedge.
- rst  input  1  reset, asynchronous and active-low (tie to aresetn).
- src  nasti_stream_channel slave  DATA_WIDTH  input pixels. Per 32-bit lane: byte0 V, byte1 U, byte2 Y, byte3 ignored.
- dst  nasti_stream_channel master  DATA_WIDTH  output pixels. Per 32-bit lane: byte0 B, byte1 G, byte2 R, byte3 0x00.

## Operation

- Per lane, studio range:
  - C = Y−16, D = U−128, E = V−128, each 9-bit signed.
  - R = clamp((298C + 409E + 128) >>> 8)
  - G = clamp((298C − 100D − 208E + 128) >>> 8)
  - B = clamp((298C + 516D + 128) >>> 8)
- Accumulators are 20-bit signed; worst case is B = 136882. `>>>` is arithmetic (floor).
- Clamp: negative → 0; >255 → 255.
- t_last, t_strb and t_keep travel unchanged alongside the data.
- Outgoing t_id, t_dest and t_user are 0.
- Incoming byte3 never affects the output.
- Pipeline, 3 register stages, each with its own valid bit:
  - S1: offsets and the five products.
  - S2: sums plus rounding constant.
  - S3: shift, clamp, pack.
- adv = !v3 | dst.t_ready. All stages shift together when adv = 1. src.t_ready = adv.
- A stage captures src data only when src.t_valid & adv. Otherwise the stage loads valid = 0 (a bubble).
- Bubbles are not collapsed while stalled. This is accepted; no throughput loss occurs while dst.t_ready = 1.

## Timing

- Reset values: v1, v2 and v3 = 0, so dst.t_valid = 0. Data registers are don't-care but reset to 0.
- Latency: a beat accepted at edge N appears on dst at edge N+3 when no stall occurs.
- dst.t_valid = v3. Once t_valid is asserted, dst.t_data, t_last, t_strb and t_keep stay stable until dst.t_ready.
- src.t_ready depends combinationally on dst.t_ready. This is the only combinational path; it is documented for integrators.
- Simultaneous accept and emit in the same cycle is permitted.
- Full throughput, one beat per cycle, is sustained while dst.t_ready = 1.
- rst asserted mid-stream:
  - All valid bits clear immediately and in-flight beats are discarded.
  - dst.t_valid falls asynchronously.
  - After deassertion the first new beat appears 3 cycles after acceptance.
- src.t_valid low with dst ready: the pipeline drains and dst.t_valid drops after the last beat.

## Configuration

- YUV_FULL_RANGE_EN defined: JPEG full-range conversion.
  - C = Y (no −16).
  - R = clamp((256C + 359E + 128) >>> 8)
  - G = clamp((256C − 88D − 183E + 128) >>> 8)
  - B = clamp((256C + 454D + 128) >>> 8)
- YUV_FULL_RANGE_EN undefined: studio-range coefficients as in Operation.
- Pipeline depth, widths and handshake are identical in both builds.

## Structure

- Shared package chroma_pkg holds:
  - typedefs yuv_pix_t {pad, y, u, v} and rgb_pix_t {pad, r, g, b}, both 32 bits with v and b in the low byte;
  - localparam coefficient constants for both ranges, selected by the macro;
  - the 20-bit accumulator width.
- Sub-module yuv2rgb_pixel is the single-lane 3-stage datapath with an enable input, generated LANES times.
- The top level owns the valid bits, the sideband pipeline and the handshake.

## Test plan

- Black/white (studio): Y=16, U=V=128 → R=G=B=0. Y=235, U=V=128 → R=G=B=255.
- Red: Y=81, U=90, V=240 → R=255, G=0, B=0. B is floored to −1 and clamped to 0.
- Saturation: Y=U=V=255 → R=255, G=125, B=255. Lane 1 carries a different pixel in the same beat to confirm lanes are independent.
- Backpressure: stream 8 beats with t_last on the 8th; drop dst.t_ready for 5 cycles mid-burst → 8 beats out, in order, no duplicates, t_last only on beat 8, data stable while stalled.
- Reset mid-stream: assert rst with 3 beats in flight → dst.t_valid = 0 during reset and no stale beat afterwards. A new beat emerges 3 cycles after acceptance.
- YUV_FULL_RANGE_EN build: Y=128, U=128, V=255 → R=255, G=37, B=128.

Source files
------------

// File: rtl/chroma_pkg.sv
// chroma_pkg: shared types and constants for the chroma colour-space path.
//   yuv_pix_t / rgb_pix_t : 32-bit lane layouts (v / b in the low byte).
//   ACC_W                 : signed accumulator width of the converter.
//   K_* / Y_OFF           : BT.601 coefficients, studio range by default,
//                           JPEG full range when YUV_FULL_RANGE_EN is defined.
package chroma_pkg;

  localparam int ACC_W = 20;  // holds the worst case 298*239 + 516*127 + 128
  localparam int RND   = 128;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv_pix_t;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

  localparam int STUDIO_Y_OFF = 16;
  localparam int STUDIO_K_Y   = 298;
  localparam int STUDIO_K_RV  = 409;
  localparam int STUDIO_K_GU  = 100;
  localparam int STUDIO_K_GV  = 208;
  localparam int STUDIO_K_BU  = 516;

  localparam int FULL_Y_OFF   = 0;
  localparam int FULL_K_Y     = 256;
  localparam int FULL_K_RV    = 359;
  localparam int FULL_K_GU    = 88;
  localparam int FULL_K_GV    = 183;
  localparam int FULL_K_BU    = 454;

`ifdef YUV_FULL_RANGE_EN
  localparam int Y_OFF = FULL_Y_OFF;
  localparam int K_Y   = FULL_K_Y;
  localparam int K_RV  = FULL_K_RV;
  localparam int K_GU  = FULL_K_GU;
  localparam int K_GV  = FULL_K_GV;
  localparam int K_BU  = FULL_K_BU;
`else
  localparam int Y_OFF = STUDIO_Y_OFF;
  localparam int K_Y   = STUDIO_K_Y;
  localparam int K_RV  = STUDIO_K_RV;
  localparam int K_GU  = STUDIO_K_GU;
  localparam int K_GV  = STUDIO_K_GV;
  localparam int K_BU  = STUDIO_K_BU;
`endif

  // Saturate a shifted accumulator to 0..255.
  function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] x);
    if (x[ACC_W-1])           return 8'h00;
    else if (x > ACC_W'(255)) return 8'hFF;
    else                      return x[7:0];
  endfunction

endpackage

// File: rtl/nasti_stream_channel_if.sv
// nasti_stream_channel: AXI4-stream style channel.
//   master drives t_valid/t_data/t_strb/t_keep/t_last/t_id/t_dest/t_user,
//   slave drives t_ready.
interface nasti_stream_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
                  input  t_ready);
  modport slave  (input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
                  output t_ready);
endinterface

// File: rtl/yuv444_to_rgb_pixel.sv
// yuv2rgb_pixel: single-lane 3-stage YCbCr -> RGB datapath.
//   clk, rst (async active-low), en (advance all stages),
//   pix_in (yuv_pix_t), pix_out (rgb_pix_t, registered, pad = 0).
// Coefficient set follows YUV_FULL_RANGE_EN via chroma_pkg.
module yuv2rgb_pixel
  import chroma_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  yuv_pix_t pix_in,
  output rgb_pix_t pix_out
);

  typedef logic signed [ACC_W-1:0] acc_t;

  logic signed [8:0] c, d, e;
  logic unused_pad;

  // 9-bit wrap is safe: every offset result lies in -128..255.
  assign c = signed'({1'b0, pix_in.y} - 9'(Y_OFF));
  assign d = signed'({1'b0, pix_in.u} - 9'd128);
  assign e = signed'({1'b0, pix_in.v} - 9'd128);
  assign unused_pad = ^pix_in.pad;

  acc_t p_y, p_rv, p_gu, p_gv, p_bu;  // S1
  acc_t s_r, s_g, s_b;                // S2

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_y  <= '0;
      p_rv <= '0;
      p_gu <= '0;
      p_gv <= '0;
      p_bu <= '0;
      s_r  <= '0;
      s_g  <= '0;
      s_b  <= '0;
      pix_out <= '0;
    end else if (en) begin
      p_y  <= ACC_W'(c) * ACC_W'(K_Y);
      p_rv <= ACC_W'(e) * ACC_W'(K_RV);
      p_gu <= ACC_W'(d) * ACC_W'(K_GU);
      p_gv <= ACC_W'(e) * ACC_W'(K_GV);
      p_bu <= ACC_W'(d) * ACC_W'(K_BU);
      s_r  <= p_y + p_rv + ACC_W'(RND);
      s_g  <= p_y - p_gu - p_gv + ACC_W'(RND);
      s_b  <= p_y + p_bu + ACC_W'(RND);
      pix_out.pad <= 8'h00;
      pix_out.r   <= clamp8(s_r >>> 8);
      pix_out.g   <= clamp8(s_g >>> 8);
      pix_out.b   <= clamp8(s_b >>> 8);
    end
  end

endmodule

// File: rtl/yuv444_to_rgb.sv
// yuv444_to_rgb: pipelined BT.601 YCbCr 4:4:4 -> XRGB stream converter.
//   clk            : clock
//   rst            : async active-low reset
//   src (slave)    : pixels, per 32-bit lane {pad, Y, U, V}
//   dst (master)   : pixels, per 32-bit lane {0x00, R, G, B}
// Three register stages, one beat per cycle while dst.t_ready is high.
// src.t_ready is combinational from dst.t_ready (only comb path).
// Build option: YUV_FULL_RANGE_EN selects JPEG full-range coefficients.
module yuv444_to_rgb
  import chroma_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic clk,
  input  logic rst,
  nasti_stream_channel.slave  src,
  nasti_stream_channel.master dst
);

  localparam int LANES  = DATA_WIDTH / 32;
  localparam int STAGES = 3;
  localparam int SB_W   = DATA_WIDTH / 8;

  logic                       adv;
  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1]            last_pipe;
  logic [STAGES:1][SB_W-1:0]  strb_pipe;
  logic [STAGES:1][SB_W-1:0]  keep_pipe;
  logic [LANES-1:0][31:0]     lane_out;
  logic                       unused_src;

  // Whole pipe moves as one; an empty or draining output slot lets it move.
  assign adv         = !vld_pipe[STAGES] | dst.t_ready;
  assign src.t_ready = adv;
  assign unused_src  = ^{src.t_id, src.t_dest, src.t_user};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      strb_pipe <= '0;
      keep_pipe <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1],  src.t_valid};
      last_pipe <= {last_pipe[STAGES-1:1], src.t_last};
      strb_pipe <= {strb_pipe[STAGES-1:1], src.t_strb};
      keep_pipe <= {keep_pipe[STAGES-1:1], src.t_keep};
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rgb_pix_t px;
    yuv2rgb_pixel u_pix (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .pix_in  (yuv_pix_t'(src.t_data[32*i +: 32])),
      .pix_out (px)
    );
    assign lane_out[i] = px;
  end

  assign dst.t_valid = vld_pipe[STAGES];
  assign dst.t_data  = lane_out;
  assign dst.t_last  = last_pipe[STAGES];
  assign dst.t_strb  = strb_pipe[STAGES];
  assign dst.t_keep  = keep_pipe[STAGES];
  assign dst.t_id    = '0;
  assign dst.t_dest  = '0;
  assign dst.t_user  = '0;

endmodule
